// File: rtl/traffic_pkg.sv
// Shared lamp codes, phase codes and timer width for the intersection scheduler.
package traffic_pkg;
  localparam int TW = 8;

  localparam logic [0:2] RED    = 3'b100;
  localparam logic [0:2] GREEN  = 3'b010;
  localparam logic [0:2] YELLOW = 3'b001;

  typedef enum logic [2:0] {
    MAIN_GREEN  = 3'd0,
    MAIN_YELLOW = 3'd1,
    ALLRED_A    = 3'd2,
    SIDE_GREEN  = 3'd3,
    SIDE_YELLOW = 3'd4,
    ALLRED_B    = 3'd5,
    WALK        = 3'd6
  } state_t;
endpackage

// File: rtl/intersection_scheduler_if.sv
// Request inputs and lamp/status outputs of the intersection scheduler.
interface intersection_scheduler_if;
  logic       side_req;
  logic       ped_req;
  logic [0:2] main_light;
  logic [0:2] side_light;
  logic       walk;
  logic       side_pending;
  logic       ped_pending;
  logic [2:0] phase;

  modport master (
    output side_req, ped_req,
    input  main_light, side_light, walk, side_pending, ped_pending, phase
  );

  modport slave (
    input  side_req, ped_req,
    output main_light, side_light, walk, side_pending, ped_pending, phase
  );
endinterface

// File: rtl/intersection_scheduler_timer.sv
// Phase down-counter: loads on state entry, decrements to 0 and saturates there.
module phase_timer
  import traffic_pkg::*;
#(
  parameter logic [TW-1:0] RST_VAL = '0
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          load,
  input  logic [TW-1:0] load_value,
  output logic          expired
);
  logic [TW-1:0] cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)         cnt <= RST_VAL;
    else if (load)        cnt <= load_value;
    else if (cnt != '0)   cnt <= cnt - TW'(1);
  end

  assign expired = (cnt == '0);
endmodule

// File: rtl/intersection_scheduler.sv
// Two-road traffic light scheduler with optional pedestrian phase.
// Define INTERSECTION_PED_EN to compile in the WALK phase and ped_req handling.
module intersection_scheduler
  import traffic_pkg::*;
#(
  parameter int MAIN_MIN     = 8,
  parameter int YELLOW_T     = 3,
  parameter int ALLRED_T     = 2,
  parameter int SIDE_GREEN_T = 6,
  parameter int WALK_T       = 5
) (
  input  logic                     clock,
  input  logic                     reset_n,
  intersection_scheduler_if.slave  bus
);
  state_t        state, state_n;
  logic          side_pnd, side_pnd_n;
  logic          ped_pnd, ped_pnd_n;
  logic          expired, load;
  logic [TW-1:0] load_value;
  logic          ped_in;

`ifdef INTERSECTION_PED_EN
  localparam bit PED_ON = 1'b1;
  assign ped_in = bus.ped_req;
`else
  localparam bit PED_ON = 1'b0;
  logic unused_ped_req;
  assign unused_ped_req = bus.ped_req;
  assign ped_in = 1'b0;
`endif

  function automatic logic [TW-1:0] dur_m1(input state_t s);
    case (s)
      MAIN_GREEN:              return TW'(MAIN_MIN - 1);
      MAIN_YELLOW, SIDE_YELLOW: return TW'(YELLOW_T - 1);
      SIDE_GREEN:              return TW'(SIDE_GREEN_T - 1);
      WALK:                    return TW'(WALK_T - 1);
      default:                 return TW'(ALLRED_T - 1);
    endcase
  endfunction

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state    <= ALLRED_B;
      side_pnd <= 1'b0;
      ped_pnd  <= 1'b0;
    end else begin
      state    <= state_n;
      side_pnd <= side_pnd_n;
      ped_pnd  <= ped_pnd_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      MAIN_GREEN:  if (expired && (side_pnd || bus.side_req || ped_pnd || ped_in))
                     state_n = MAIN_YELLOW;
      MAIN_YELLOW: if (expired) state_n = ALLRED_A;
      ALLRED_A:    if (expired) state_n = (side_pnd || !PED_ON) ? SIDE_GREEN : WALK;
      SIDE_GREEN:  if (expired) state_n = SIDE_YELLOW;
      SIDE_YELLOW: if (expired) state_n = ALLRED_B;
      ALLRED_B:    if (expired) state_n = ped_pnd ? WALK : MAIN_GREEN;
      WALK:        if (expired) state_n = MAIN_GREEN;
      default:     state_n = ALLRED_B;
    endcase
  end

  // A flag is cleared on the edge entering its serving phase and ignores its
  // request until that phase is being left.
  always_comb begin
    side_pnd_n = (state_n == SIDE_GREEN) ? 1'b0 : (side_pnd | bus.side_req);
    ped_pnd_n  = PED_ON && (state_n != WALK) && (ped_pnd | ped_in);
  end

  assign load       = (state_n != state);
  assign load_value = dur_m1(state_n);

  phase_timer #(
    .RST_VAL (TW'(ALLRED_T - 1))
  ) u_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .expired    (expired)
  );

  assign bus.main_light   = (state == MAIN_GREEN)  ? GREEN :
                            (state == MAIN_YELLOW) ? YELLOW : RED;
  assign bus.side_light   = (state == SIDE_GREEN)  ? GREEN :
                            (state == SIDE_YELLOW) ? YELLOW : RED;
  assign bus.walk         = PED_ON && (state == WALK);
  assign bus.side_pending = side_pnd;
  assign bus.ped_pending  = ped_pnd;
  assign bus.phase        = state;
endmodule

// File: tb/tb_intersection_scheduler.sv
// Bench for intersection_scheduler: directed phase sequences plus a random run against a phase model.
module tb_intersection_scheduler;
  localparam int MAIN_MIN = 8, YELLOW_T = 3, ALLRED_T = 2, SIDE_GREEN_T = 6, WALK_T = 5;
  localparam logic [0:2] LR = 3'b100, LG = 3'b010, LY = 3'b001;
`ifdef INTERSECTION_PED_EN
  localparam bit PED = 1'b1;
`else
  localparam bit PED = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  intersection_scheduler_if bus();

  intersection_scheduler #(
    .MAIN_MIN(MAIN_MIN), .YELLOW_T(YELLOW_T), .ALLRED_T(ALLRED_T),
    .SIDE_GREEN_T(SIDE_GREEN_T), .WALK_T(WALK_T)
  ) dut (
    .clock   (clock),
    .reset_n (reset_n),
    .bus     (bus)
  );

  always #5 clock = ~clock;

  int n_chk = 0;
  int n_fail = 0;
  int exp_q[$];

  function automatic logic [0:2] main_of(input int ph);
    return (ph == 0) ? LG : (ph == 1) ? LY : LR;
  endfunction

  function automatic logic [0:2] side_of(input int ph);
    return (ph == 3) ? LG : (ph == 4) ? LY : LR;
  endfunction

  function automatic int dur(input int ph);
    case (ph)
      0: return MAIN_MIN;
      1, 4: return YELLOW_T;
      3: return SIDE_GREEN_T;
      6: return WALK_T;
      default: return ALLRED_T;
    endcase
  endfunction

  task automatic add(input int ph, input int n);
    repeat (n) exp_q.push_back(ph);
  endtask

  // Leaves the bench at the sample point of the first MAIN_GREEN cycle.
  task automatic do_reset();
    bus.side_req = 1'b0;
    bus.ped_req  = 1'b0;
    @(negedge clock); reset_n = 1'b0;
    @(negedge clock); reset_n = 1'b1;
    @(negedge clock);
    @(negedge clock);
  endtask

  task automatic test_reset();
    do_reset();
    repeat (3) @(negedge clock);
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.phase, bus.main_light, bus.side_light, bus.walk, bus.side_pending, bus.ped_pending}
        !== {3'd5, LR, LR, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL reset_async phase=%0d main=%b side=%b walk=%b sp=%b pp=%b, expected 5/100/100/0/0/0",
               bus.phase, bus.main_light, bus.side_light, bus.walk, bus.side_pending, bus.ped_pending);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 102; i++) begin
      n_chk++;
      if ({bus.phase, bus.main_light, bus.side_light} !== {(i < 2) ? 3'd5 : 3'd0, (i < 2) ? LR : LG, LR}) begin
        n_fail++;
        $display("FAIL reset_release cycle %0d phase=%0d main=%b side=%b", i, bus.phase, bus.main_light, bus.side_light);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_side();
    exp_q.delete();
    add(0, 8); add(1, 3); add(2, 2); add(3, 6); add(4, 3); add(5, 2); add(0, 3);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if ({bus.phase, bus.main_light, bus.side_light, bus.walk}
          !== {3'(exp_q[i]), main_of(exp_q[i]), side_of(exp_q[i]), 1'b0}) begin
        n_fail++;
        $display("FAIL side_seq cycle %0d phase=%0d main=%b side=%b walk=%b, expected phase %0d",
                 i, bus.phase, bus.main_light, bus.side_light, bus.walk, exp_q[i]);
      end
      if (i == 3 || i == 13) begin
        n_chk++;
        if (bus.side_pending !== (i == 3)) begin
          n_fail++;
          $display("FAIL side_pending cycle %0d got %b expected %b", i, bus.side_pending, (i == 3));
        end
      end
      bus.side_req = (i == 2);
      @(negedge clock);
    end
  endtask

  task automatic test_ped();
    logic pp_exp;
    exp_q.delete();
`ifdef INTERSECTION_PED_EN
    add(0, 8); add(1, 3); add(2, 2); add(6, 5); add(0, 3);
`else
    add(0, 24);
`endif
    pp_exp = PED;
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if ({bus.phase, bus.main_light, bus.side_light, bus.walk}
          !== {3'(exp_q[i]), main_of(exp_q[i]), side_of(exp_q[i]), (exp_q[i] == 6)}) begin
        n_fail++;
        $display("FAIL ped_seq cycle %0d phase=%0d main=%b side=%b walk=%b, expected phase %0d",
                 i, bus.phase, bus.main_light, bus.side_light, bus.walk, exp_q[i]);
      end
      if (i == 3) begin
        n_chk++;
        if (bus.ped_pending !== pp_exp) begin
          n_fail++;
          $display("FAIL ped_pending got %b expected %b", bus.ped_pending, pp_exp);
        end
      end
      bus.ped_req = (i == 2);
      @(negedge clock);
    end
  endtask

  task automatic test_both();
    exp_q.delete();
    add(0, 8); add(1, 3); add(2, 2); add(3, 6); add(4, 3); add(5, 2);
`ifdef INTERSECTION_PED_EN
    add(6, 5);
`endif
    add(0, 3);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if ({bus.phase, bus.main_light, bus.side_light, bus.walk}
          !== {3'(exp_q[i]), main_of(exp_q[i]), side_of(exp_q[i]), (exp_q[i] == 6)}) begin
        n_fail++;
        $display("FAIL both_seq cycle %0d phase=%0d main=%b side=%b walk=%b, expected phase %0d",
                 i, bus.phase, bus.main_light, bus.side_light, bus.walk, exp_q[i]);
      end
      bus.side_req = (i == 2);
      bus.ped_req  = (i == 2);
      @(negedge clock);
    end
  endtask

  task automatic test_side_hold();
    exp_q.delete();
    add(0, 8); add(1, 3); add(2, 2); add(3, 6); add(4, 3); add(5, 2); add(0, 8); add(1, 1);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if ({bus.phase, bus.main_light, bus.side_light}
          !== {3'(exp_q[i]), main_of(exp_q[i]), side_of(exp_q[i])}) begin
        n_fail++;
        $display("FAIL hold_seq cycle %0d phase=%0d expected %0d", i, bus.phase, exp_q[i]);
      end
      if (i >= 13 && i <= 19) begin
        n_chk++;
        if (bus.side_pending !== (i == 19)) begin
          n_fail++;
          $display("FAIL hold_pending cycle %0d got %b expected %b", i, bus.side_pending, (i == 19));
        end
      end
      bus.side_req = (i == 2) || (i >= 12 && i <= 18);
      @(negedge clock);
    end
  endtask

  task automatic test_reset_mid_side();
    exp_q.delete();
    add(0, 8); add(1, 3); add(2, 2); add(3, 4);
    do_reset();
    for (int i = 0; i < exp_q.size(); i++) begin
      n_chk++;
      if (bus.phase !== 3'(exp_q[i])) begin
        n_fail++;
        $display("FAIL midrst_seq cycle %0d phase=%0d expected %0d", i, bus.phase, exp_q[i]);
      end
      bus.side_req = (i == 2);
      bus.ped_req  = (i == 14);
      if (i < exp_q.size() - 1) @(negedge clock);
    end
    bus.ped_req = 1'b0;
    reset_n = 1'b0;
    #1;
    n_chk++;
    if ({bus.phase, bus.main_light, bus.side_light, bus.walk, bus.side_pending, bus.ped_pending}
        !== {3'd5, LR, LR, 1'b0, 1'b0, 1'b0}) begin
      n_fail++;
      $display("FAIL midrst_async phase=%0d main=%b side=%b sp=%b pp=%b, expected 5/100/100/0/0",
               bus.phase, bus.main_light, bus.side_light, bus.side_pending, bus.ped_pending);
    end
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_chk++;
      if ({bus.phase, bus.main_light} !== {(i < 2) ? 3'd5 : 3'd0, (i < 2) ? LR : LG}) begin
        n_fail++;
        $display("FAIL midrst_release cycle %0d phase=%0d main=%b", i, bus.phase, bus.main_light);
      end
      @(negedge clock);
    end
  endtask

  // Random requests checked against a phase/remaining-cycles model.
  task automatic test_random();
    int  m_ph, m_left, nxt;
    bit  m_sp, m_pp, sr, pr, go;
    do_reset();
    m_ph = 0; m_left = MAIN_MIN; m_sp = 0; m_pp = 0;
    for (int c = 0; c < 3000; c++) begin
      n_chk++;
      if ({bus.phase, bus.main_light, bus.side_light, bus.walk, bus.side_pending, bus.ped_pending}
          !== {3'(m_ph), main_of(m_ph), side_of(m_ph), (m_ph == 6), m_sp, m_pp}) begin
        n_fail++;
        $display("FAIL random cycle %0d phase=%0d sp=%b pp=%b walk=%b, expected phase=%0d sp=%b pp=%b",
                 c, bus.phase, bus.side_pending, bus.ped_pending, bus.walk, m_ph, m_sp, m_pp);
      end
      sr = ($urandom_range(0, 15) == 0);
      pr = ($urandom_range(0, 19) == 0);
      bus.side_req = sr;
      bus.ped_req  = pr;
      go = (m_left <= 1) && (m_ph != 0 || m_sp || sr || (PED && (m_pp || pr)));
      case (m_ph)
        0: nxt = 1;
        1: nxt = 2;
        2: nxt = (m_sp || !PED) ? 3 : 6;
        3: nxt = 4;
        4: nxt = 5;
        5: nxt = m_pp ? 6 : 0;
        default: nxt = 0;
      endcase
      if (go && nxt == 3) m_sp = 0;
      else if (!(m_ph == 3 && !go)) m_sp = m_sp | sr;
      if (go && nxt == 6) m_pp = 0;
      else if (!(m_ph == 6 && !go)) m_pp = PED && (m_pp | pr);
      if (go) begin
        m_ph = nxt;
        m_left = dur(nxt);
      end else if (m_left > 1) begin
        m_left--;
      end
      @(negedge clock);
    end
    bus.side_req = 1'b0;
    bus.ped_req  = 1'b0;
  endtask

  initial begin
    bus.side_req = 1'b0;
    bus.ped_req  = 1'b0;
    repeat (3) @(negedge clock);
    reset_n = 1'b1;
    test_reset();
    test_side();
    test_ped();
    test_both();
    test_side_hold();
    test_reset_mid_side();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/intersection_scheduler.md
INTERSECTION_SCHEDULER -- requirements
Module: intersection_scheduler

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-low reset.
REQ-002 Parameter MAIN_MIN, default 8, minimum main-road green duration in cycles.
REQ-003 Parameter YELLOW_T, default 3, yellow duration in cycles, used for both roads.
REQ-004 Parameter ALLRED_T, default 2, all-red clearance duration in cycles.
REQ-005 Parameter SIDE_GREEN_T, default 6, side-road green duration in cycles.
REQ-006 Parameter WALK_T, default 5, pedestrian walk duration in cycles.
REQ-007 Port clock, input, 1, rising-edge system clock.
REQ-008 Port reset_n, input, 1, asynchronous active-low reset.
REQ-009 Port side_req, input, 1, side-road vehicle sensor; level or single-cycle pulse.
REQ-010 Port ped_req, input, 1, pedestrian push-button; level or single-cycle pulse.
REQ-011 Port main_light, output, [0:2], one-hot lamp code RED=100, GREEN=010, YELLOW=001.
REQ-012 Port side_light, output, [0:2], same encoding as main_light.
REQ-013 Port walk, output, 1, pedestrian walk lamp.
REQ-014 Port side_pending and port ped_pending, outputs, 1 each, latched-request status.
REQ-015 Port phase, output, 3, current state code.

Function
REQ-016 The block SHALL have these states and codes: MAIN_GREEN=0, MAIN_YELLOW=1, ALLRED_A=2, SIDE_GREEN=3, SIDE_YELLOW=4, ALLRED_B=5, WALK=6.
REQ-017 On state entry, the timer SHALL load the state duration minus 1 and then decrement once per cycle, so a state of duration D lasts exactly D cycles.
REQ-018 MAIN_GREEN SHALL exit to MAIN_YELLOW only when the timer is 0 and (side_pending | side_req | ped_pending | ped_req) is true; otherwise it SHALL hold indefinitely with the timer saturated at 0.
REQ-019 MAIN_YELLOW SHALL go to ALLRED_A.
REQ-020 ALLRED_A SHALL go to SIDE_GREEN if a side request is pending, otherwise to WALK.
REQ-021 SIDE_GREEN SHALL go to SIDE_YELLOW, and SIDE_YELLOW SHALL go to ALLRED_B.
REQ-022 ALLRED_B SHALL go to WALK if a pedestrian request is pending, otherwise to MAIN_GREEN.
REQ-023 WALK SHALL go to MAIN_GREEN.
REQ-024 Each request flag SHALL set on any cycle its request input is high.
REQ-025 side_pending SHALL clear on the edge entering SIDE_GREEN, and side_req SHALL be ignored while in SIDE_GREEN.
REQ-026 ped_pending SHALL clear on the edge entering WALK, and ped_req SHALL be ignored while in WALK.
REQ-027 A request input that is high on the same edge as a flag clear SHALL NOT re-set the flag.
REQ-028 Lamp outputs SHALL be decoded combinationally from the state register, with zero latency after a state change.
REQ-029 Lamp decode: main_light is GREEN only in MAIN_GREEN and YELLOW only in MAIN_YELLOW; side_light is GREEN only in SIDE_GREEN and YELLOW only in SIDE_YELLOW; all other lamp values are RED.
REQ-030 walk SHALL be 1 only in WALK.
REQ-031 The two roads SHALL never be non-RED at the same time.
REQ-032 Every duration parameter SHALL be in the range 1..255; the timer width is 8 bits.

Reset
REQ-033 While reset_n is 0, the block SHALL hold state=ALLRED_B, timer=ALLRED_T-1, both pending flags=0, main_light=side_light=RED, walk=0 and phase=5.
REQ-034 A reset asserted in any state SHALL force these values immediately, with no clock required.
REQ-035 After reset is released with no requests, main_light SHALL become GREEN after ALLRED_T cycles.

Configuration
REQ-036 The macro INTERSECTION_PED_EN SHALL compile in the pedestrian path.
REQ-037 When INTERSECTION_PED_EN is defined, the WALK state, the ped_pending flag and the walk output SHALL behave as specified above.
REQ-038 When INTERSECTION_PED_EN is undefined, the ped_req port SHALL exist but be ignored, walk and ped_pending SHALL be tied to 0, the WALK state SHALL not exist, and ALLRED_A SHALL always go to SIDE_GREEN.

Structure
REQ-039 A shared package traffic_pkg SHALL hold the lamp constants RED, GREEN and YELLOW, the state code constants, and the timer width constant TW=8.
REQ-040 A sub-module phase_timer SHALL contain the timer, with inputs load and load_value and output expired, which is high when the timer is 0.

Verification
REQ-041 Reset release with no requests -> all lamps RED for 2 cycles, then main_light=GREEN, held for 100 cycles with phase=0.
REQ-042 Single-cycle side_req pulse in the 3rd MAIN_GREEN cycle -> side_pending=1 on the next cycle; main GREEN for 8 cycles total, then yellow 3, all-red 2, side GREEN 6 (side_pending=0 on entry), side yellow 3, all-red 2, then main GREEN.
REQ-043 ped_req pulse only -> after the MAIN_MIN green: main yellow 3, all-red 2, WALK with walk=1 and both lamps RED for 5 cycles, then main GREEN.
REQ-044 side_req and ped_req pulsed on the same cycle -> the side phase is served first, then ALLRED_B, then WALK 5, then MAIN_GREEN; no all-red gap between WALK and MAIN_GREEN.
REQ-045 side_req held high throughout SIDE_GREEN, then dropped in SIDE_YELLOW -> side_pending is 0 during SIDE_GREEN and goes to 1 in the first SIDE_YELLOW cycle.
REQ-046 reset_n pulled low in the 4th SIDE_GREEN cycle -> both lamps RED and both flags 0 with no clock edge, then main GREEN 2 cycles after release.
